srl_fifo: RTL and testbench



---
 rtl/srl_fifo_pkg.sv | 17 +
 rtl/srl_fifo_bank.sv | 26 ++
 rtl/srl_fifo.sv | 95 +++++++++
 tb/tb_srl_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_fifo_pkg.sv
// Shared types and constants for the SRL-based FIFO (srl_fifo).
package srl_fifo_pkg;

  localparam int SRL_MAX_DEPTH = 32;

  typedef logic [5:0] lvl_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int SRL_AW = clog2(SRL_MAX_DEPTH);

endpackage

// File: rtl/srl_fifo_bank.sv
// WIDTH lanes of 32-deep addressable shift registers (SRLC32E behaviour, INIT=0).
// All lanes share the shift enable and the read address.
module srl_fifo_bank
  import srl_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_ce,
  input  logic [SRL_AW-1:0] i_a,
  input  logic [WIDTH-1:0]  i_d,
  output logic [WIDTH-1:0]  o_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic [SRL_MAX_DEPTH-1:0] r_srl;

    // New data enters at bit 0; address k reads the word shifted in k pushes ago.
    always_ff @(posedge i_clk) begin
      if (i_ce) r_srl <= {r_srl[SRL_MAX_DEPTH-2:0], i_d[g]};
    end

    assign o_q[g] = r_srl[i_a];
  end

endmodule

// File: rtl/srl_fifo.sv
// Valid/ready FIFO over SRL storage; read address = occupancy - 1.
// Define SRL_FIFO_OREG_EN to add a registered output stage (capacity DEPTH+1).
module srl_fifo
  import srl_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output lvl_t             LEVEL
);

  if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH) begin : g_bad_depth
    $error("srl_fifo: DEPTH must be in 2..32");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("srl_fifo: WIDTH must be in 1..64");
  end

  // Handshake: a word moves on a side when its valid and ready are both high
  // at the rising edge; ready never depends on the same side's valid.
  lvl_t              r_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_srl_valid;
  logic [SRL_AW-1:0] w_addr;
  logic [WIDTH-1:0]  w_q;

  assign S_READY     = (r_cnt != lvl_t'(DEPTH));
  assign w_push      = S_VALID & S_READY;
  assign w_srl_valid = (r_cnt != '0);
  assign w_addr      = r_cnt[SRL_AW-1:0] - SRL_AW'(1);

  srl_fifo_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .i_clk (CLK),
    .i_ce  (w_push),
    .i_a   (w_addr),
    .i_d   (S_DATA),
    .o_q   (w_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + lvl_t'(1);
        2'b01:   r_cnt <= r_cnt - lvl_t'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef SRL_FIFO_OREG_EN
  logic             r_oreg_v;
  logic [WIDTH-1:0] r_oreg;

  // The SRL head moves into the output register whenever that slot is free
  // or being drained this cycle.
  assign w_pop = w_srl_valid & (~r_oreg_v | M_READY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_oreg_v <= 1'b0;
      r_oreg   <= '0;
    end else begin
      if (w_pop) begin
        r_oreg_v <= 1'b1;
        r_oreg   <= w_q;
      end else if (M_READY) begin
        r_oreg_v <= 1'b0;
      end
    end
  end

  assign M_VALID = r_oreg_v;
  assign M_DATA  = r_oreg;
  assign LEVEL   = r_cnt + lvl_t'(r_oreg_v);
`else
  assign w_pop   = w_srl_valid & M_READY;
  assign M_VALID = w_srl_valid;
  assign M_DATA  = w_q;
  assign LEVEL   = r_cnt;
`endif

endmodule

// File: tb/tb_srl_fifo.sv
// Self-checking bench for srl_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_srl_fifo;
  import srl_fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
`ifdef SRL_FIFO_OREG_EN
  localparam int  CAP        = DEPTH + 1;
  localparam bit  OREG       = 1'b1;
  localparam logic LAT1_VALID = 1'b0;
  localparam int  STREAM_LVL = 2;
  localparam int  STREAM_POPS = 99;
`else
  localparam int  CAP        = DEPTH;
  localparam bit  OREG       = 1'b0;
  localparam logic LAT1_VALID = 1'b1;
  localparam int  STREAM_LVL = 1;
  localparam int  STREAM_POPS = 100;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  lvl_t             level;

  always #5 clk = ~clk;

  srl_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .S_VALID (s_valid),
    .S_READY (s_ready),
    .S_DATA  (s_data),
    .M_VALID (m_valid),
    .M_READY (m_ready),
    .M_DATA  (m_data),
    .LEVEL   (level)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // All words held, oldest first. With the output stage, m_head_out says
  // whether the oldest word already sits in the output register.
  logic [WIDTH-1:0] exp_q[$];
  bit               m_head_out = 1'b0;
  int               m_srl_n;
  bit               m_push;
  bit               m_pop;

  function automatic int model_srl_count();
    return exp_q.size() - ((OREG && m_head_out) ? 1 : 0);
  endfunction

  function automatic bit model_m_valid();
    return OREG ? m_head_out : (exp_q.size() != 0);
  endfunction

  function automatic bit model_s_ready();
    return model_srl_count() != DEPTH;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_head_out = 1'b0;
    end else begin
      m_srl_n = model_srl_count();
      m_push  = s_valid && model_s_ready();
      m_pop   = m_ready && model_m_valid();
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(s_data);
      if (OREG) m_head_out = (m_head_out && !m_pop) || (m_srl_n > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", 64'(m_valid), 64'(model_m_valid()));
      chk("s_ready", 64'(s_ready), 64'(model_s_ready()));
      chk("level", 64'(level), 64'(exp_q.size()));
      if (model_m_valid()) chk("m_data", 64'(m_data), 64'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    m_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int               n_pop;
  logic [WIDTH-1:0] exp_pop;

  initial begin
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    idle(2);
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_level", 64'(level), 64'd0);

    // latency from empty
    push_word(8'h5A);
    chk("lat1_m_valid", 64'(m_valid), 64'(LAT1_VALID));
    step();
    chk("lat2_m_valid", 64'(m_valid), 64'd1);
    chk("lat2_m_data", 64'(m_data), 64'h5A);
    drain(2);
    chk("lat_empty_level", 64'(level), 64'd0);

    // three words, then pop in order
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    idle(1);
    chk("three_level", 64'(level), 64'd3);
    chk("three_head", 64'(m_data), 64'h11);
    m_ready = 1'b1;
    chk("pop0", 64'(m_data), 64'h11);
    step();
    chk("pop1", 64'(m_data), 64'h22);
    step();
    chk("pop2", 64'(m_data), 64'h33);
    step();
    m_ready = 1'b0;
    chk("three_empty", 64'(m_valid), 64'd0);

    // fill past capacity; only the first CAP offered words are taken
    s_valid = 1'b1;
    for (int i = 0; i < CAP + 8; i++) begin
      s_data = WIDTH'(i);
      step();
    end
    s_valid = 1'b0;
    chk("full_level", 64'(level), 64'(CAP));
    chk("full_s_ready", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    n_pop = 0;
    for (int i = 0; i < CAP + 4; i++) begin
      if (m_valid) begin
        chk("drain_order", 64'(m_data), 64'(n_pop));
        n_pop++;
      end
      step();
    end
    m_ready = 1'b0;
    chk("drain_count", 64'(n_pop), 64'(CAP));

    // sustained push+pop starting from one word
    push_word(8'h00);
    idle(1);
    s_valid = 1'b1;
    m_ready = 1'b1;
    n_pop   = 0;
    exp_pop = '0;
    for (int i = 1; i <= 100; i++) begin
      s_data = WIDTH'(i);
      if (m_valid) begin
        chk("stream_seq", 64'(m_data), 64'(exp_pop));
        exp_pop = exp_pop + 1'b1;
        n_pop++;
      end
      step();
    end
    chk("stream_level", 64'(level), 64'(STREAM_LVL));
    chk("stream_pops", 64'(n_pop), 64'(STREAM_POPS));
    drain(4);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      s_valid = ($urandom_range(0, 99) < 60);
      m_ready = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 40 : 75));
      s_data  = WIDTH'($urandom_range(0, 255));
      step();
    end
    drain(CAP + 2);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    chk("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1;
    #1;
    chk("async_rst_level", 64'(level), 64'd0);
    chk("async_rst_m_valid", 64'(m_valid), 64'd0);
    chk("async_rst_s_ready", 64'(s_ready), 64'd1);
    #1 rst = 1'b0;
    push_word(8'hAA);
    chk("post_rst_lat1", 64'(m_valid), 64'(LAT1_VALID));
    step();
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_data", 64'(m_data), 64'hAA);
    drain(2);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
